// File: rtl/onehot_dec_pkg.sv
// onehot_dec_pkg: shared shift-direction codes and one-hot helper for the decoder family.
package onehot_dec_pkg;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  function automatic logic [31:0] onehot(input logic [4:0] i);
    return 32'd1 << i;
  endfunction
endpackage

// File: rtl/decoder_n_to_2n.sv
// decoder_n_to_2n: combinational binary-to-one-hot decoder with enable gating.
module decoder_n_to_2n #(
  parameter int SEL_W = 3,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] a,
  input  logic             en,
  output logic [OUT_W-1:0] d
);
  always_comb d = en ? (OUT_W'(1) << a) : '0;
endmodule

// File: rtl/onehot_shift_decoder.sv
// onehot_shift_decoder: registered one-hot decoder with a walking-bit shifter that wraps or shifts out at the ends.
module onehot_shift_decoder
  import onehot_dec_pkg::*;
#(
  parameter int SEL_W = 3,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [SEL_W-1:0] sel,
  input  logic             shift,
  input  logic             dir,
  input  logic             wrap,
  output logic [OUT_W-1:0] d,
  output logic [SEL_W-1:0] idx,
  output logic             valid,
  output logic             shift_out
);
  logic [SEL_W-1:0] idx_nx;
  logic valid_nx, so_nx, at_end;
  // Ends are detected explicitly so wrap never relies on arithmetic overflow.
  always_comb begin
    at_end = (dir == DIR_UP) ? (idx == '1) : (idx == '0);
    idx_nx = idx;
    valid_nx = valid;
    so_nx = 1'b0;
    if (enable && load) begin
      idx_nx = sel;
      valid_nx = 1'b1;
    end else if (enable && shift && valid) begin
      if (!at_end) idx_nx = (dir == DIR_UP) ? idx + 1'b1 : idx - 1'b1;
      else if (wrap) idx_nx = (dir == DIR_UP) ? '0 : '1;
      else begin
        valid_nx = 1'b0;
        so_nx = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      valid <= 1'b0;
      shift_out <= 1'b0;
    end else begin
      idx <= idx_nx;
      valid <= valid_nx;
      shift_out <= so_nx;
    end
  decoder_n_to_2n #(.SEL_W(SEL_W)) u_dec (.a(idx), .en(enable && valid), .d(d));
endmodule

// File: tb/tb_onehot_shift_decoder.sv
// tb_onehot_shift_decoder: directed vectors for the SEL_W=3 and SEL_W=4 configurations.
module tb_onehot_shift_decoder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b0, load = 1'b0, shift = 1'b0, dir = 1'b0, wrap = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] d;
  logic [2:0] idx;
  logic valid, so;
  logic b_en = 1'b0, b_load = 1'b0, b_shift = 1'b0, b_dir = 1'b0, b_wrap = 1'b0;
  logic [3:0] b_sel = '0;
  logic [15:0] b_d;
  logic [3:0] b_idx;
  logic b_valid, b_so;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  onehot_shift_decoder #(.SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .load(load), .sel(sel), .shift(shift),
    .dir(dir), .wrap(wrap), .d(d), .idx(idx), .valid(valid), .shift_out(so)
  );
  onehot_shift_decoder #(.SEL_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(b_en), .load(b_load), .sel(b_sel), .shift(b_shift),
    .dir(b_dir), .wrap(b_wrap), .d(b_d), .idx(b_idx), .valid(b_valid), .shift_out(b_so)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(input string tag, input logic [7:0] ed, input logic [2:0] ei, input logic ev, input logic es);
    chk({tag, ".d"}, 32'(d), 32'(ed));
    chk({tag, ".idx"}, 32'(idx), 32'(ei));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".so"}, 32'(so), 32'(es));
  endtask
  logic [2:0] up_seq [3] = '{3'd7, 3'd0, 3'd1};
  logic [7:0] up_d [3] = '{8'h80, 8'h01, 8'h02};
  initial begin
    #1;
    chk_a("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      step();
      chk_a($sformatf("load%0d", i), 8'(1 << i), 3'(i), 1'b1, 1'b0);
    end
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      step();
      chk_a($sformatf("load_dis%0d", i), 8'h00, 3'd7, 1'b1, 1'b0);
    end
    en = 1'b1;
    sel = 3'd6;
    step();
    load = 1'b0;
    shift = 1'b1;
    wrap = 1'b1;
    dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a($sformatf("wrap_up%0d", i), up_d[i], up_seq[i], 1'b1, 1'b0);
    end
    dir = 1'b1;
    step();
    chk_a("wrap_dn0", 8'h01, 3'd0, 1'b1, 1'b0);
    step();
    chk_a("wrap_dn1", 8'h80, 3'd7, 1'b1, 1'b0);
    shift = 1'b0;
    load = 1'b1;
    sel = 3'd1;
    wrap = 1'b0;
    step();
    load = 1'b0;
    shift = 1'b1;
    step();
    chk_a("sout0", 8'h01, 3'd0, 1'b1, 1'b0);
    step();
    chk_a("sout1", 8'h00, 3'd0, 1'b0, 1'b1);
    step();
    chk_a("sout2", 8'h00, 3'd0, 1'b0, 1'b0);
    load = 1'b1;
    sel = 3'd3;
    dir = 1'b0;
    step();
    chk_a("prio", 8'h08, 3'd3, 1'b1, 1'b0);
    load = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a($sformatf("freeze%0d", i), 8'h00, 3'd3, 1'b1, 1'b0);
    end
    shift = 1'b0;
    en = 1'b1;
    #1;
    chk_a("reenable", 8'h08, 3'd3, 1'b1, 1'b0);
    load = 1'b1;
    sel = 3'd5;
    step();
    load = 1'b0;
    chk_a("pre_rst", 8'h20, 3'd5, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    b_en = 1'b1;
    b_load = 1'b1;
    b_sel = 4'd15;
    b_wrap = 1'b1;
    step();
    b_load = 1'b0;
    b_shift = 1'b1;
    step();
    chk("w4_wrap.idx", 32'(b_idx), 32'd0);
    chk("w4_wrap.d", 32'(b_d), 32'h0001);
    b_shift = 1'b0;
    b_load = 1'b1;
    b_wrap = 1'b0;
    step();
    chk("w4_load.d", 32'(b_d), 32'h8000);
    b_load = 1'b0;
    b_shift = 1'b1;
    step();
    chk("w4_sout.so", 32'(b_so), 32'd1);
    chk("w4_sout.d", 32'(b_d), 32'h0000);
    chk("w4_sout.valid", 32'(b_valid), 32'd0);
    b_shift = 1'b0;
    step();
    chk("w4_sout_end.so", 32'(b_so), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/onehot_shift_decoder.md
Name: onehot_shift_decoder

Overview:
Parametrised registered binary-to-one-hot decoder with a built-in walking-bit shifter. It is the next generation of the team's combinational 3-to-8 enable decoder. A binary index is loaded into a state register and decoded to a one-hot output. The active bit can then be stepped up or down each clock, with wrap-around or shift-out at the ends. It drives chip-select and scan-strobe generation in the team's datapath blocks.

Parameters:
SEL_W, 3, width of binary select/index
OUT_W, 2**SEL_W (derived localparam, not overridable), width of one-hot output

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  block enable; 0 freezes state and forces d to zero
load  input  1  load sel into index register (priority over shift)
sel  input  SEL_W  binary index to load
shift  input  1  step active bit one position this cycle
dir  input  1  0 = up (index+1), 1 = down (index-1)
wrap  input  1  1 = wrap at ends; 0 = shift bit out at ends
d  output  OUT_W  one-hot output, bit idx high when active
idx  output  SEL_W  current index register
valid  output  1  a bit is currently held
shift_out  output  1  one-cycle pulse: bit shifted off an end with wrap=0

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). Reset values: idx=0, valid=0, shift_out=0, and d=0.
- State registers are idx, valid and shift_out. d is combinational from the registers: d = (enable && valid) ? (1 << idx) : 0.
- Latency: a load or shift sampled at edge k is visible on d/idx/valid right after edge k (1 cycle from input to output).
- Per-edge update priority when enable=1:
  1. load=1: idx<=sel, valid<=1, shift_out<=0. Any shift in the same cycle is ignored.
  2. shift=1 and valid=1, dir=0: idx<OUT_W-1 -> idx+1. At idx=OUT_W-1 with wrap=1 -> idx<=0. At idx=OUT_W-1 with wrap=0 -> valid<=0, idx unchanged, shift_out<=1.
  3. shift=1 and valid=1, dir=1: idx>0 -> idx-1. At idx=0 with wrap=1 -> idx<=OUT_W-1. At idx=0 with wrap=0 -> valid<=0, shift_out<=1.
  4. shift=1 and valid=0: no state change, shift_out<=0.
  5. Otherwise: hold, shift_out<=0.
- enable=0: idx and valid hold, load and shift are ignored, shift_out<=0, d=0. On re-enable, d reflects the held state immediately (combinationally).
- shift_out is high for exactly one cycle per shift-out event. It cannot be high while valid=1.
- Index arithmetic is modulo 2**SEL_W. Wrap never depends on overflow side effects; ends are detected explicitly.
- Reset mid-operation (rst_n low at any time, asynchronously): all registers clear immediately, and d drops to 0 without waiting for a clock.
- sel is used as-is (all 2**SEL_W codes are legal). No X-propagation from unloaded state, because valid gates d.

Decomposition:
- Shared package onehot_dec_pkg:
  - constants DIR_UP=1'b0 and DIR_DOWN=1'b1
  - helper function onehot(idx) returning 1<<idx
- One sub-module: decoder_n_to_2n.
  - Parametrised on SEL_W; inputs a and en, output d.
  - Purely combinational; instantiated once to decode idx gated by enable&&valid.
  - Also reusable by other blocks.

Test Plan:
- Reset: rst_n=0 mid-run with idx=5, valid=1 -> d=8'h00, idx=0, valid=0 asynchronously, before the next clk edge.
- Load sweep: SEL_W=3, enable=1, load each sel 0..7 for one cycle -> d=8'h01,02,04,...,80 one cycle after each load, valid=1. Repeat with enable=0 -> d=0 and idx unchanged.
- Wrap up/down: load 6, wrap=1, dir=0, shift 3 cycles -> idx 7,0,1 (d=80,01,02). Then dir=1, shift 2 -> idx 0,7.
- Shift-out: load 1, wrap=0, dir=1, shift 2 cycles -> idx 0 (d=01), then valid=0, d=0, shift_out=1 for one cycle. A further shift -> no change, shift_out=0.
- Priority and freeze: load=1, sel=3 with shift=1 in the same cycle -> idx=3 (not 4). Then enable=0 with shift=1 for 3 cycles -> idx stays 3, d=0. After enable=1 -> d=8'h08.
- Parameter: SEL_W=4 -> load 15, wrap=1, shift up -> idx=0, d=16'h0001. Load 15, wrap=0, shift up -> shift_out pulse, d=0.
